// File: rtl/weight_update_ctrl_pkg.sv
// Shared Q6.10 constants, FSM encoding and 16-bit saturation helper for the
// weight update controller.
package weight_update_ctrl_pkg;
    localparam int Q_FRAC = 10;
    localparam int DATA_W = 16;
    localparam int PROD_W = 32;

    localparam logic signed [DATA_W-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] Q_MIN = 16'sh8000;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef struct packed {
        logic signed [DATA_W-1:0] value;
        logic                     clamped;
    } sat16_t;

    function automatic sat16_t sat16(input logic signed [PROD_W-1:0] x);
        sat16_t r;
        if (x > PROD_W'(Q_MAX)) begin
            r.value   = Q_MAX;
            r.clamped = 1'b1;
        end else if (x < PROD_W'(Q_MIN)) begin
            r.value   = Q_MIN;
            r.clamped = 1'b1;
        end else begin
            r.value   = x[DATA_W-1:0];
            r.clamped = 1'b0;
        end
        return r;
    endfunction
endpackage

// File: rtl/weight_update_ctrl_if.sv
// Scheduler handshake plus activation/weight RAM ports of the update controller.
interface weight_update_ctrl_if #(
    parameter int ADDR_W = 4
);
    import weight_update_ctrl_pkg::*;

    logic                     start;
    logic signed [DATA_W-1:0] delta;
    logic [ADDR_W-1:0]        act_addr;
    logic signed [DATA_W-1:0] act_data;
    logic [ADDR_W-1:0]        w_addr;
    logic signed [DATA_W-1:0] w_rdata;
    logic                     w_we;
    logic signed [DATA_W-1:0] w_wdata;
    logic                     busy;
    logic                     done;
    logic                     sat_flag;

    modport master (
        input  start, delta, act_data, w_rdata,
        output act_addr, w_addr, w_we, w_wdata, busy, done, sat_flag
    );

    modport slave (
        output start, delta, act_data, w_rdata,
        input  act_addr, w_addr, w_we, w_wdata, busy, done, sat_flag
    );
endinterface

// File: rtl/weight_update_ctrl_mul_sat.sv
// Registered signed Q6.10 multiply; product is rescaled and clamped to 16 bits.
module q610_mul_sat
    import weight_update_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] dw,
    output logic                     sat
);
    logic signed [PROD_W-1:0] p;
    sat16_t                   r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            p <= '0;
        end else if (en) begin
            p <= a * b;
        end
    end

    assign r   = sat16(p >>> Q_FRAC);
    assign dw  = r.value;
    assign sat = r.clamped;
endmodule

// File: rtl/weight_update_ctrl.sv
// Per-node weight update sequencer: w[i] <= sat(w[i] - (sat(delta*a[i]) >>> LR_SHIFT)).
// state | meaning
// IDLE  | waiting for start
// RD    | addresses driven with idx
// MUL   | RAM data valid, product and weight captured
// WR    | updated weight written, advance or finish
// DONE  | one-cycle completion pulse, start accepted here
module weight_update_ctrl
    import weight_update_ctrl_pkg::*;
#(
    parameter int N_WEIGHTS = 16,
    parameter int ADDR_W    = 4,
    parameter int LR_SHIFT  = 3
) (
    input logic                  clk,
    input logic                  rst,
    weight_update_ctrl_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WEIGHTS - 1);

    logic [2:0]               state;
    logic [ADDR_W-1:0]        idx;
    logic signed [DATA_W-1:0] delta_q;
    logic signed [DATA_W-1:0] w_reg;
    logic                     sat_q;
    logic signed [DATA_W-1:0] dw;
    logic                     mul_sat;
    logic signed [DATA_W-1:0] step;
    logic signed [DATA_W:0]   diff;
    sat16_t                   res;

    q610_mul_sat u_mul (
        .clk (clk),
        .rst (rst),
        .en  (state == S_MUL),
        .a   (delta_q),
        .b   (bus.act_data),
        .dw  (dw),
        .sat (mul_sat)
    );

    assign step = dw >>> LR_SHIFT;
    assign diff = (DATA_W+1)'(w_reg) - (DATA_W+1)'(step);
    assign res  = sat16(PROD_W'(diff));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            delta_q <= '0;
            w_reg   <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state   <= S_RD;
                        idx     <= '0;
                        delta_q <= bus.delta;
                        sat_q   <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RD: state <= S_MUL;
                S_MUL: begin
                    w_reg <= bus.w_rdata;
                    state <= S_WR;
                end
                S_WR: begin
                    if (mul_sat || res.clamped) sat_q <= 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + ADDR_W'(1);
                        state <= S_RD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.act_addr = idx;
    assign bus.w_addr   = idx;
    assign bus.w_we     = (state == S_WR);
    assign bus.w_wdata  = (state == S_WR) ? res.value : '0;
    assign bus.busy     = (state == S_RD) || (state == S_MUL) || (state == S_WR);
    assign bus.done     = (state == S_DONE);
    assign bus.sat_flag = sat_q;
endmodule

// File: tb/tb_weight_update_ctrl.sv
// Directed bench for weight_update_ctrl: a 1-weight and a 16-weight instance with RAM models.
module tb_weight_update_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [15:0] act1 [16];
    logic [15:0] w1   [16];
    logic [15:0] act16[16];
    logic [15:0] w16  [16];

    int          wn1 = 0, dn1 = 0, done_cyc1 = 0;
    logic [15:0] wr_data1[16];
    int          wr_cyc1[16];
    int          wn16 = 0, dn16 = 0, done_cyc16 = 0;
    int          wr_addr16[128];
    logic [15:0] wr_data16[128];
    int          wr_cyc16[128];

    weight_update_ctrl_if #(.ADDR_W(4)) bus1 ();
    weight_update_ctrl_if #(.ADDR_W(4)) bus16 ();

    weight_update_ctrl #(.N_WEIGHTS(1), .ADDR_W(4), .LR_SHIFT(3)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1));
    weight_update_ctrl #(.N_WEIGHTS(16), .ADDR_W(4), .LR_SHIFT(3)) dut16 (
        .clk (clk), .rst (rst), .bus (bus16));

    // RAM models (1-cycle read latency) and write/done loggers
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus1.act_data  <= act1[bus1.act_addr];
        bus1.w_rdata   <= w1[bus1.w_addr];
        bus16.act_data <= act16[bus16.act_addr];
        bus16.w_rdata  <= w16[bus16.w_addr];
        if (bus1.w_we === 1'b1 && wn1 < 16) begin
            wr_data1[wn1] <= bus1.w_wdata;
            wr_cyc1[wn1]  <= cyc;
            wn1 <= wn1 + 1;
        end
        if (bus16.w_we === 1'b1 && wn16 < 128) begin
            wr_addr16[wn16] <= int'(bus16.w_addr);
            wr_data16[wn16] <= bus16.w_wdata;
            wr_cyc16[wn16]  <= cyc;
            wn16 <= wn16 + 1;
        end
        if (bus1.done === 1'b1) begin dn1 <= dn1 + 1; done_cyc1 <= cyc; end
        if (bus16.done === 1'b1) begin dn16 <= dn16 + 1; done_cyc16 <= cyc; end
    end

    task automatic start1(input logic [15:0] d, output int s);
        bus1.delta = d; bus1.start = 1'b1; s = cyc;
        @(negedge clk);
        bus1.start = 1'b0;
    endtask

    task automatic start16(input logic [15:0] d, output int s);
        bus16.delta = d; bus16.start = 1'b1; s = cyc;
        @(negedge clk);
        bus16.start = 1'b0;
    endtask

    task automatic wait_done1();
        int n = 0;
        while (bus1.done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        vectors++;
        if (bus1.done !== 1'b1) begin
            $display("FAIL wait_done1: done=%b after %0d cycles, required 1", bus1.done, n);
            miscompares++;
        end
    endtask

    task automatic wait_done16();
        int n = 0;
        while (bus16.done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        vectors++;
        if (bus16.done !== 1'b1) begin
            $display("FAIL wait_done16: done=%b after %0d cycles, required 1", bus16.done, n);
            miscompares++;
        end
    endtask

    task automatic check_idle16(input string name);
        logic [31:0] got;
        got = {bus16.busy, bus16.done, bus16.w_we, bus16.sat_flag, bus16.act_addr,
               bus16.w_addr, bus16.w_wdata, 4'h0};
        vectors++;
        if (got !== 32'h0) begin
            $display("FAIL %s: {busy,done,we,sat,aaddr,waddr,wdata}=%h required 0", name, got);
            miscompares++;
        end
    endtask

    task automatic check_run16(input string name, input int base, input int s,
                               input logic [15:0] exp [16]);
        vectors++;
        if (wn16 - base !== 16) begin
            $display("FAIL %s_count: %0d writes, required 16", name, wn16 - base);
            miscompares++;
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (wr_addr16[base+i] !== i || wr_data16[base+i] !== exp[i] ||
                wr_cyc16[base+i] !== s + 3 + 3*i) begin
                $display("FAIL %s[%0d]: addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                         name, i, wr_addr16[base+i], wr_data16[base+i], wr_cyc16[base+i] - s,
                         i, exp[i], 3 + 3*i);
                miscompares++;
            end
        end
        vectors++;
        if (done_cyc16 !== s + 49) begin
            $display("FAIL %s_done_cyc: %0d required %0d", name, done_cyc16 - s, 49);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle16("reset16");
        vectors++;
        if ({bus1.busy, bus1.done, bus1.w_we, bus1.sat_flag, bus1.w_wdata, bus1.w_addr} !== 24'h0) begin
            $display("FAIL reset1: busy=%b done=%b we=%b sat=%b wdata=%h waddr=%h required all 0",
                     bus1.busy, bus1.done, bus1.w_we, bus1.sat_flag, bus1.w_wdata, bus1.w_addr);
            miscompares++;
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int s, base;
        act1[0] = 16'h0800; w1[0] = 16'h0400; base = wn1;
        start1(16'h0200, s);
        vectors++;
        if (bus1.busy !== 1'b1) begin
            $display("FAIL basic_busy: %b required 1", bus1.busy); miscompares++;
        end
        wait_done1();
        @(negedge clk);
        vectors++;
        if (wn1 - base !== 1 || wr_data1[base] !== 16'h0380 || wr_cyc1[base] !== s + 3) begin
            $display("FAIL basic_write: n=%0d data=%h cyc=%0d required n=1 data=0380 cyc=3",
                     wn1 - base, wr_data1[base], wr_cyc1[base] - s);
            miscompares++;
        end
        vectors++;
        if (done_cyc1 !== s + 4 || bus1.done !== 1'b0 || bus1.sat_flag !== 1'b0) begin
            $display("FAIL basic_done: done_cyc=%0d done_now=%b sat=%b required 4, 0, 0",
                     done_cyc1 - s, bus1.done, bus1.sat_flag);
            miscompares++;
        end
    endtask

    task automatic test_saturation();
        int s, base;
        act1[0] = 16'h7FFF; w1[0] = 16'h8000; base = wn1;
        start1(16'h7FFF, s);
        wait_done1();
        repeat (4) @(negedge clk);
        vectors++;
        if (wr_data1[base] !== 16'h8000) begin
            $display("FAIL sat_wdata: %h required 8000", wr_data1[base]); miscompares++;
        end
        vectors++;
        if (bus1.sat_flag !== 1'b1) begin
            $display("FAIL sat_flag_held: %b required 1", bus1.sat_flag); miscompares++;
        end
    endtask

    task automatic test_sweep();
        int s, base;
        logic [15:0] exp [16];
        for (int i = 0; i < 16; i++) begin
            act16[i] = 16'(i << 10); w16[i] = 16'h0000; exp[i] = 16'(-(i << 7));
        end
        base = wn16;
        start16(16'h0400, s);
        wait_done16();
        @(negedge clk);
        check_run16("sweep", base, s, exp);
    endtask

    task automatic test_back_to_back();
        int s, base, d0;
        logic [15:0] exp [16];
        for (int i = 0; i < 16; i++) begin act16[i] = 16'h7FFF; w16[i] = 16'h8000; end
        start16(16'h7FFF, s);
        wait_done16();
        vectors++;
        if (bus16.sat_flag !== 1'b1) begin
            $display("FAIL b2b_sat_before: %b required 1", bus16.sat_flag); miscompares++;
        end
        for (int i = 0; i < 16; i++) begin
            act16[i] = 16'h0400; w16[i] = 16'h0100; exp[i] = 16'h0000;
        end
        d0 = dn16 + 1;
        bus16.delta = 16'h0800; bus16.start = 1'b1; s = cyc;
        @(negedge clk);
        base = wn16;
        bus16.start = 1'b0;
        vectors++;
        if (bus16.busy !== 1'b1 || bus16.sat_flag !== 1'b0 || bus16.done !== 1'b0) begin
            $display("FAIL b2b_restart: busy=%b sat=%b done=%b required 1,0,0",
                     bus16.busy, bus16.sat_flag, bus16.done);
            miscompares++;
        end
        @(negedge clk);
        bus16.start = 1'b1; bus16.delta = 16'h0000;
        @(negedge clk);
        bus16.start = 1'b0;
        wait_done16();
        @(negedge clk);
        check_run16("b2b", base, s, exp);
        vectors++;
        if (dn16 !== d0 + 1 || bus16.sat_flag !== 1'b0) begin
            $display("FAIL b2b_tail: done_pulses=%0d sat=%b required %0d, 0", dn16, bus16.sat_flag, d0 + 1);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        int s, base, d0;
        logic [15:0] exp [16];
        for (int i = 0; i < 16; i++) begin
            act16[i] = 16'h0400; w16[i] = 16'h0100; exp[i] = 16'h0080;
        end
        base = wn16; d0 = dn16;
        start16(16'h0400, s);
        repeat (17) @(negedge clk);
        vectors++;
        if (bus16.w_we !== 1'b1 || bus16.w_addr !== 4'd5) begin
            $display("FAIL rmid_in_wr5: we=%b addr=%0d required 1, 5", bus16.w_we, bus16.w_addr);
            miscompares++;
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle16("rmid_after");
        rst = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (wn16 - base !== 6 || dn16 !== d0) begin
            $display("FAIL rmid_aborted: writes=%0d done_pulses=%0d required 6, 0", wn16 - base, dn16 - d0);
            miscompares++;
        end
        base = wn16;
        start16(16'h0400, s);
        wait_done16();
        @(negedge clk);
        check_run16("rmid_restart", base, s, exp);
    endtask

    task automatic test_zero();
        int s, base;
        logic [15:0] exp [16];
        for (int i = 0; i < 16; i++) begin
            act16[i] = 16'(i * 16'h0111); w16[i] = 16'h1234; exp[i] = 16'h1234;
        end
        base = wn16;
        start16(16'h0000, s);
        wait_done16();
        @(negedge clk);
        check_run16("zero", base, s, exp);
        vectors++;
        if (bus16.sat_flag !== 1'b0) begin
            $display("FAIL zero_sat: %b required 0", bus16.sat_flag); miscompares++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            act1[i] = '0; w1[i] = '0; act16[i] = '0; w16[i] = '0;
        end
        bus1.start = 1'b0;  bus1.delta = '0;
        bus16.start = 1'b0; bus16.delta = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_sweep();
        test_back_to_back();
        test_reset_mid();
        test_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/weight_update_ctrl.md
Name: weight_update_ctrl

Overview:
Sequences the per-layer weight update for one output node: for every weight index i it reads activation a[i] and weight w[i], forms dw = delta*a[i] in Q6.10, and writes back w[i] - (dw >>> LR_SHIFT) with saturation. It sits between the backprop delta source and the weight/activation RAMs and owns the single dw multiplier. Start/busy/done handshake toward the layer scheduler.

Parameters:
N_WEIGHTS, 16, number of weights updated per run (1..2^ADDR_W)
ADDR_W, 4, width of weight/activation address
LR_SHIFT, 3, learning rate as 2^-LR_SHIFT (0..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
start  in  1  run request, sampled in IDLE or DONE only
delta  in  16  signed Q6.10 error term, latched on accepted start
act_addr  out  ADDR_W  activation RAM read address
act_data  in  16  signed Q6.10 activation, valid 1 cycle after act_addr
w_addr  out  ADDR_W  weight RAM address (read and write)
w_rdata  in  16  signed Q6.10 weight, valid 1 cycle after w_addr
w_we  out  1  weight write strobe
w_wdata  out  16  signed Q6.10 updated weight
busy  out  1  high while a run is in progress
done  out  1  one-cycle pulse after last write
sat_flag  out  1  sticky: any saturation during current/last run

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE, idx=0, act_addr=w_addr=0, w_we=0, w_wdata=0, busy=0, done=0, sat_flag=0, delta register=0. Reset mid-run aborts immediately; no further write is issued.
- States: IDLE, RD, MUL, WR, DONE.
- IDLE: start=1 -> latch delta, idx=0, clear sat_flag, go RD. Otherwise stay.
- RD: drive act_addr=w_addr=idx; busy=1. Next MUL.
- MUL: act_data/w_rdata valid; register product p = delta*act_data (32-bit signed) and w_reg = w_rdata. Next WR.
- WR: w_addr=idx, w_we=1, w_wdata=result. If idx==N_WEIGHTS-1 go DONE, else idx++ and go RD.
- DONE: done=1, busy=0 for exactly this cycle. start=1 here is accepted (same as IDLE, go RD); else go IDLE.
- start while busy (RD/MUL/WR) is ignored; delta changes during a run are ignored.
- Timing: accepted start at edge k -> first RD in cycle k+1; 3 cycles per weight; done high in cycle k+1+3*N_WEIGHTS.
- w_we is high only in WR; addresses hold idx through RD..WR.
- Arithmetic: dw = p >>> 10, saturated to [-32768, 32767] (sets sat_flag if clamped). step = dw >>> LR_SHIFT (arithmetic). diff = w_reg - step in 17 bits, saturated to 16 bits (sets sat_flag if clamped). w_wdata = saturated diff.
- delta=0 or act=0: weight is rewritten unchanged.
- sat_flag holds until the next accepted start or reset.

Decomposition:
- Shared package: Q_FRAC=10, DATA_W=16, PROD_W=32, Q6.10 MAX/MIN constants, state encoding, a saturate-to-16 function.
- One sub-module: q610_mul_sat (registered 16x16 signed multiply, >>>10, saturate, sat output), enable driven in MUL.
- FSM, index counter and update adder stay in weight_update_ctrl.

Test Plan:
- Basic: N=1, LR_SHIFT=3, delta=0x0200 (0.5), a=0x0800 (2.0), w=0x0400 (1.0) -> single write w_wdata=0x0380, sat_flag=0, done 4 cycles after start.
- Sweep: N=16, delta=0x0400, a[i]=i<<10, w[i]=0 -> w[i]=-(i<<7) at addresses 0..15 in order, 16 w_we pulses each 3 cycles apart, one done pulse.
- Saturation: delta=0x7FFF, a=0x7FFF, w=0x8000 -> dw clamps 0x7FFF, step 0x0FFF, w_wdata=0x8000, sat_flag=1 held after done.
- Busy/start: start pulsed during MUL, and delta changed mid-run -> ignored, results use latched delta; start in DONE -> new run begins next cycle, sat_flag cleared.
- Reset mid-run: rst=0 in WR of idx 5 -> w_we=0 next cycle, busy=0, no done pulse, all outputs at reset values; restart completes normally.
- Zero: delta=0x0000, w[i]=0x1234 -> every w_wdata=0x1234, sat_flag=0.
